full_adder_reg: RTL and testbench
=================================

Name: full_adder_reg

Overview:
Registered full adder. It adds two operand words and a carry-in, and presents sum and carry-out one clock later. With the default WIDTH=1 it is the classic 1-bit full adder (A+B+Cin -> S, Cout). It is a leaf arithmetic cell used in ALU and counter datapaths, and as a teaching and regression block for the arithmetic library.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in, weight 2^0.
- in_valid  input  1  qualifies A/B/Cin for capture this cycle.
- S  output  WIDTH  registered sum, low WIDTH bits of A+B+Cin.
- Cout  output  1  registered carry-out, bit WIDTH of A+B+Cin.
- out_valid  output  1  high for one cycle when S/Cout hold a new result.

Behaviour:
- Arithmetic: {Cout,S} = A + B + Cin, computed at WIDTH+1 bits with unsigned, zero-extended operands. No overflow is lost.
- Per-bit logic, ripple form:
  - s[i] = a[i]^b[i]^c[i]
  - c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i])
  - c[0] = Cin, Cout = c[WIDTH]
- Latency is exactly 1 cycle. Inputs are sampled at a rising clk edge with in_valid=1, and the result appears on S/Cout after that edge. Throughput is one result per cycle.
- out_valid is registered and equals in_valid from the previous edge.
- When in_valid=0 at an edge: S and Cout hold their previous values, and out_valid goes to 0.
- Reset: while reset=1, S=0, Cout=0 and out_valid=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-stream discards any captured result.
  - After reset deasserts, the first edge with in_valid=1 produces a result one cycle later.
- No internal state exists beyond the S, Cout and out_valid registers.
- All-ones boundary: A=B=all ones with Cin=1 gives S=all ones, Cout=1. A=B=0 with Cin=0 gives S=0, Cout=0.
- Outputs never glitch between edges, except the asynchronous assertion of reset.
- X/Z on A/B/Cin while in_valid=0 must not affect the outputs.

Test Plan:
- WIDTH=1 exhaustive truth table. Drive (A,B,Cin) = 000, 010, 100, 110, 001, 011, 101, 111 with in_valid=1, one vector per 10 ns clock.
  - Required (S,Cout) one cycle later: 00, 10, 10, 01, 10, 01, 01, 11.
  - out_valid=1 throughout.
- Reset behaviour. Assert reset asynchronously mid-cycle while S=1, Cout=1 are being output -> S=0, Cout=0, out_valid=0 immediately. After release, apply A=1, B=0, Cin=1 -> S=0, Cout=1 on the next cycle.
- Hold behaviour. After A=1, B=1, Cin=0 gives S=0, Cout=1, drop in_valid for 3 cycles with inputs toggling randomly -> S=0, Cout=1 are held and out_valid=0.
- WIDTH=4 carry ripple:
  - A=4'hF, B=4'h0, Cin=1 -> S=4'h0, Cout=1.
  - A=4'h7, B=4'h8, Cin=0 -> S=4'hF, Cout=0.
- WIDTH=8 random regression. 1000 back-to-back random vectors with in_valid=1 -> each {Cout,S} equals A+B+Cin from the previous cycle, and out_valid=1 on every cycle.

Source files
------------

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {Cout,S} = A + B + Cin, presented one clock after capture.
// WIDTH=1 is the classic single-bit full adder cell.
module full_adder_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;

    // Explicit ripple chain; carry[i] is the carry into bit i.
    always_comb begin
        carry    = '0;
        sum_d    = '0;
        carry[0] = Cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_d[i]   = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    end

    // Result registers load only on a valid capture, so inputs are ignored otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            S    <= '0;
            Cout <= 1'b0;
        end else if (in_valid) begin
            S    <= sum_d;
            Cout <= carry[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_full_adder_reg.sv
// Scoreboard bench for full_adder_reg at WIDTH=1, 4 and 8: drivers push expected results,
// per-instance monitors pop and compare whenever out_valid is seen.
module tb_full_adder_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       a1, b1, c1, iv1, s1, co1, ov1;
    logic [3:0] a4, b4, s4;
    logic       c4, iv4, co4, ov4;
    logic [7:0] a8, b8, s8;
    logic       c8, iv8, co8, ov8;

    full_adder_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .A(a1), .B(b1), .Cin(c1), .in_valid(iv1),
        .S(s1), .Cout(co1), .out_valid(ov1)
    );
    full_adder_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .A(a4), .B(b4), .Cin(c4), .in_valid(iv4),
        .S(s4), .Cout(co4), .out_valid(ov4)
    );
    full_adder_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .A(a8), .B(b8), .Cin(c8), .in_valid(iv8),
        .S(s8), .Cout(co8), .out_valid(ov8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] q1[$];
    logic [4:0] q4[$];
    logic [8:0] q8[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitors: compare {Cout,S} against the queue head on every valid output.
    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) check("w1 unexpected out_valid", 16'(ov1), 16'd0);
            else check("w1 result", 16'({co1, s1}), 16'(q1.pop_front()));
        end
    end
    always @(negedge clk) begin
        if (ov4 === 1'b1) begin
            if (q4.size() == 0) check("w4 unexpected out_valid", 16'(ov4), 16'd0);
            else check("w4 result", 16'({co4, s4}), 16'(q4.pop_front()));
        end
    end
    always @(negedge clk) begin
        if (ov8 === 1'b1) begin
            if (q8.size() == 0) check("w8 unexpected out_valid", 16'(ov8), 16'd0);
            else check("w8 result", 16'({co8, s8}), 16'(q8.pop_front()));
        end
    end

    task automatic drv1(input logic a, input logic b, input logic c, input logic [1:0] exp);
        @(posedge clk); #2;
        a1 = a; b1 = b; c1 = c; iv1 = 1'b1;
        q1.push_back(exp);
    endtask

    task automatic drv4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [4:0] exp);
        @(posedge clk); #2;
        a4 = a; b4 = b; c4 = c; iv4 = 1'b1;
        q4.push_back(exp);
    endtask

    task automatic idle_all();
        @(posedge clk); #2;
        iv1 = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
    endtask

    // (A,B,Cin) and hand-computed {Cout,S}.
    logic [2:0] tt_in  [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    logic [1:0] tt_exp [8] = '{2'b00,  2'b01,  2'b01,  2'b10,  2'b01,  2'b10,  2'b10,  2'b11};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a1 = 0; b1 = 0; c1 = 0; iv1 = 0;
        a4 = 0; b4 = 0; c4 = 0; iv4 = 0;
        a8 = 0; b8 = 0; c8 = 0; iv8 = 0;
        #1;
        check("reset w1", 16'({co1, s1, ov1}), 16'd0);
        check("reset w4", 16'({co4, s4, ov4}), 16'd0);
        check("reset w8", 16'({co8, s8, ov8}), 16'd0);
        @(posedge clk); #3 reset = 1'b0;

        // WIDTH=1 truth table, back to back.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = tt_in[i];
            drv1(v[2], v[1], v[0], tt_exp[i]);
        end

        // Mid-cycle asynchronous reset while S=1, Cout=1 is presented.
        drv1(1'b1, 1'b1, 1'b1, 2'b11);
        @(posedge clk); #2 iv1 = 1'b0;
        #5;
        check("pre-reset output", 16'({co1, s1, ov1}), 16'b111);
        reset = 1'b1;
        #1;
        check("async reset clears", 16'({co1, s1, ov1}), 16'd0);
        @(posedge clk); #3 reset = 1'b0;
        drv1(1'b1, 1'b0, 1'b1, 2'b10);

        // Hold: outputs keep the last result while in_valid is low.
        drv1(1'b1, 1'b1, 1'b0, 2'b10);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); iv1 = 1'b0;
            if (k > 0) check("hold", 16'({co1, s1, ov1}), 16'b100);
        end
        @(posedge clk); #2;
        check("hold", 16'({co1, s1, ov1}), 16'b100);

        // WIDTH=4 carry ripple and boundaries.
        drv4(4'hF, 4'h0, 1'b1, 5'h10);
        drv4(4'h7, 4'h8, 1'b0, 5'h0F);
        drv4(4'hF, 4'hF, 1'b1, 5'h1F);
        drv4(4'h0, 4'h0, 1'b0, 5'h00);
        drv4(4'h5, 4'hA, 1'b1, 5'h10);
        idle_all();

        // WIDTH=8 random regression, back to back.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a, b;
            logic       c;
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            @(posedge clk); #2;
            a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
            q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
        end
        idle_all();
        repeat (3) @(posedge clk);
        #2;
        check("w1 results outstanding", 16'(q1.size()), 16'd0);
        check("w4 results outstanding", 16'(q4.size()), 16'd0);
        check("w8 results outstanding", 16'(q8.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
